// File: rtl/spi_iccm_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_loader_pkg
//  Purpose  : Shared types, default widths and helpers for the SPI ICCM
//             boot loader (top, interface and receive shifter).
//  Contents : loader_state_e    - loader FSM states
//             c_DEF_*           - default parameter values
//             bit_cnt_width()   - width of a 0..DATA_WIDTH bit counter
//  Revision : 1.0 - initial release
// ============================================================================
package spi_loader_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } loader_state_e;

  localparam int c_DEF_DATA_WIDTH = 32;
  localparam int c_DEF_ADDR_WIDTH = 12;
  localparam int c_DEF_ICCM_DEPTH = 4096;
  localparam int c_DEF_RST_DELAY  = 4;

  // The counter must hold the value DATA_WIDTH itself (word complete).
  function automatic int bit_cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_iccm_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_iccm_loader_if
//  Purpose  : Bundles the loader's control, SPI and ICCM-write signals.
//  Modports : slave  - loader side (consumes en_i/SPI, drives ICCM + status)
//             master - environment side (drives en_i/SPI, observes the rest)
//  Signals  : en_i, spi_ss, spi_mosi, iccm_cntrl_reset, iccm_cntrl_we,
//             iccm_cntrl_addr, iccm_cntrl_data, enable_rst_ni, word_count,
//             frame_err, overflow
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_iccm_loader_if
  import spi_loader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
);
  logic                  en_i;
  logic                  spi_ss;
  logic                  spi_mosi;
  logic                  iccm_cntrl_reset;
  logic                  iccm_cntrl_we;
  logic [ADDR_WIDTH-1:0] iccm_cntrl_addr;
  logic [DATA_WIDTH-1:0] iccm_cntrl_data;
  logic                  enable_rst_ni;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  frame_err;
  logic                  overflow;

  modport slave (
    input  en_i, spi_ss, spi_mosi,
    output iccm_cntrl_reset, iccm_cntrl_we, iccm_cntrl_addr, iccm_cntrl_data,
    output enable_rst_ni, word_count, frame_err, overflow
  );

  modport master (
    output en_i, spi_ss, spi_mosi,
    input  iccm_cntrl_reset, iccm_cntrl_we, iccm_cntrl_addr, iccm_cntrl_data,
    input  enable_rst_ni, word_count, frame_err, overflow
  );

endinterface
`default_nettype wire

// File: rtl/spi_iccm_loader_rx_shift.sv
`default_nettype none
// ============================================================================
//  Module   : spi_rx_shift
//  Purpose  : SPI frame deserialiser. Shifts MSB-first bits while spi_ss is
//             low, flags a completed word once per low period and reports
//             frames cut short by spi_ss rising.
//  Ports    : clk_i, rst_ni      - clock / async active-low reset
//             i_enable           - capture allowed (loader in LOAD)
//             i_flush            - drop any partial word silently
//             i_ss, i_mosi       - SPI select (active low) and data
//             o_word_valid       - 1-cycle pulse, o_word holds the word
//             o_word             - assembled word
//             o_partial_abort    - spi_ss rose with 1..DATA_WIDTH-1 bits
//  Revision : 1.0 - initial release
// ============================================================================
module spi_rx_shift
  import spi_loader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_ss,
  input  logic                  i_mosi,
  output logic                  o_word_valid,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_partial_abort
);

  localparam int              c_CW   = bit_cnt_width(DATA_WIDTH);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DATA_WIDTH);

  logic [c_CW-1:0]       r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_word_valid;

  logic w_active;
  logic w_sample;
  logic w_last;

  assign w_active = i_enable & ~i_flush;
  // The counter parks at c_FULL after a word, so extra bits in the same
  // low period are ignored until spi_ss goes high and clears it.
  assign w_sample = w_active & ~i_ss & (r_bit_cnt != c_FULL);
  assign w_last   = w_sample & (r_bit_cnt == c_FULL - 1'b1);

  assign o_partial_abort = w_active & i_ss & (r_bit_cnt != '0) & (r_bit_cnt != c_FULL);
  assign o_word_valid    = r_word_valid;
  assign o_word          = r_shift;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= w_last;
      if (!w_active || i_ss) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_sample) begin
        r_shift <= {r_shift[DATA_WIDTH-2:0], i_mosi};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_iccm_loader.sv
`default_nettype none
// ============================================================================
//  Module   : spi_iccm_loader
//  Purpose  : SPI-slave boot loader. Writes received words sequentially into
//             the ICCM while holding it in load mode and the core in reset;
//             on en_i releases the ICCM, then the core after RST_DELAY cycles.
//  Ports    : clk_i  - system clock
//             rst_ni - asynchronous active-low reset
//             bus    - spi_iccm_loader_if.slave (en_i, SPI, ICCM write port,
//                      enable_rst_ni, word_count, frame_err, overflow)
//  Revision : 1.0 - initial release
// ============================================================================
module spi_iccm_loader
  import spi_loader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
  parameter int ICCM_DEPTH = c_DEF_ICCM_DEPTH,
  parameter int RST_DELAY  = c_DEF_RST_DELAY
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  spi_iccm_loader_if.slave   bus
);

  localparam int                c_DLYW     = $clog2(RST_DELAY + 1);
  localparam logic [c_DLYW-1:0] c_DLY_LAST = c_DLYW'(RST_DELAY - 1);
  localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH + 1)'(ICCM_DEPTH);

  loader_state_e r_state;
  loader_state_e w_next_state;

  logic [c_DLYW-1:0]     r_dly;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_frame_err;
  logic                  r_overflow;

  logic                  w_word_valid;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_partial_abort;

  // Capture is enabled only in LOAD; en_i flushes a partial frame in the
  // same cycle it is sampled, so no frame error is raised for it.
  spi_rx_shift #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .i_enable        (r_state == LOAD),
    .i_flush         (bus.en_i),
    .i_ss            (bus.spi_ss),
    .i_mosi          (bus.spi_mosi),
    .o_word_valid    (w_word_valid),
    .o_word          (w_word),
    .o_partial_abort (w_partial_abort)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOAD:    if (bus.en_i) w_next_state = RELEASE;
      RELEASE: if (r_dly == c_DLY_LAST) w_next_state = RUN;
      RUN:     w_next_state = RUN;
      default: w_next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dly <= '0;
    end else if (r_state == RELEASE) begin
      r_dly <= r_dly + 1'b1;
    end else begin
      r_dly <= '0;
    end
  end

  // A word pulse can only originate in LOAD, and a pulse pending in the
  // cycle en_i is sampled is still written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_word_count <= '0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_word_valid) begin
        if (r_word_count < c_DEPTH) begin
          r_we         <= 1'b1;
          r_addr       <= r_word_count[ADDR_WIDTH-1:0];
          r_data       <= w_word;
          r_word_count <= r_word_count + 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end
      if (w_partial_abort) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign bus.iccm_cntrl_reset = (r_state == LOAD);
  assign bus.enable_rst_ni    = (r_state == RUN);
  assign bus.iccm_cntrl_we    = r_we;
  assign bus.iccm_cntrl_addr  = r_addr;
  assign bus.iccm_cntrl_data  = r_data;
  assign bus.word_count       = r_word_count;
  assign bus.frame_err        = r_frame_err;
  assign bus.overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_spi_iccm_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_iccm_loader
//  Purpose  : Self-checking bench. Two loaders (ICCM_DEPTH 4096 and 4) see
//             identical stimulus; a per-DUT queue holds expected writes and
//             is drained by a strobe monitor on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_iccm_loader;
  import spi_loader_pkg::*;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic tb_en   = 1'b0;
  logic tb_ss   = 1'b1;
  logic tb_mosi = 1'b0;

  always #5 clk = ~clk;

  spi_iccm_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus0 ();
  spi_iccm_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus1 ();

  assign bus0.en_i = tb_en;  assign bus0.spi_ss = tb_ss;  assign bus0.spi_mosi = tb_mosi;
  assign bus1.en_i = tb_en;  assign bus1.spi_ss = tb_ss;  assign bus1.spi_mosi = tb_mosi;

  spi_iccm_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .ICCM_DEPTH(4096), .RST_DELAY(4)) dut0 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus0)
  );
  spi_iccm_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .ICCM_DEPTH(4), .RST_DELAY(4)) dut1 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [43:0] q0[$];
  logic [43:0] q1[$];
  int m_cnt0 = 0;
  int m_cnt1 = 0;

  task automatic clear_model();
    q0.delete(); q1.delete();
    m_cnt0 = 0;  m_cnt1 = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    if (m_cnt0 < 4096) begin q0.push_back({m_cnt0[11:0], w}); m_cnt0++; end
    if (m_cnt1 < 4)    begin q1.push_back({m_cnt1[11:0], w}); m_cnt1++; end
  endtask

  // ---------------- strobe monitors ----------------
  always @(negedge clk) begin : mon0
    logic [43:0] e;
    if (rst_n && bus0.iccm_cntrl_we === 1'b1) begin
      if (q0.size() == 0) check_eq("d0_unexpected_we", bus0.iccm_cntrl_we, 1'b0);
      else begin
        e = q0.pop_front();
        check_eq("d0_write", {bus0.iccm_cntrl_addr, bus0.iccm_cntrl_data}, e);
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [43:0] e;
    if (rst_n && bus1.iccm_cntrl_we === 1'b1) begin
      if (q1.size() == 0) check_eq("d1_unexpected_we", bus1.iccm_cntrl_we, 1'b0);
      else begin
        e = q1.pop_front();
        check_eq("d1_write", {bus1.iccm_cntrl_addr, bus1.iccm_cntrl_data}, e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Invariant between helpers: time is 1 unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tb_ss = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [63:0] pat, input int n);
    logic [63:0] p;
    p = pat;
    for (int i = 0; i < n; i++) begin
      tb_ss   = 1'b0;
      tb_mosi = p[63];
      p       = p << 1;
      tick();
    end
  endtask

  // Full frame with expectation queued first; leaves spi_ss high, no wait.
  task automatic frame(input logic [31:0] w, input bit expect_write);
    if (expect_write) push_word(w);
    send_bits({w, 32'h0}, 32);
    tb_ss = 1'b1;
  endtask

  task automatic check_dut(input int d, input logic e_iccm_rst, input logic e_core_rstn,
                           input logic [12:0] e_cnt, input logic e_ferr, input logic e_ovf);
    logic       ir, cr, fe, ov;
    logic [12:0] wc;
    if (d == 0) begin
      ir = bus0.iccm_cntrl_reset; cr = bus0.enable_rst_ni; wc = bus0.word_count;
      fe = bus0.frame_err;        ov = bus0.overflow;
    end else begin
      ir = bus1.iccm_cntrl_reset; cr = bus1.enable_rst_ni; wc = bus1.word_count;
      fe = bus1.frame_err;        ov = bus1.overflow;
    end
    check_eq($sformatf("d%0d_iccm_cntrl_reset", d), ir, e_iccm_rst);
    check_eq($sformatf("d%0d_enable_rst_ni", d), cr, e_core_rstn);
    check_eq($sformatf("d%0d_word_count", d), wc, e_cnt);
    check_eq($sformatf("d%0d_frame_err", d), fe, e_ferr);
    check_eq($sformatf("d%0d_overflow", d), ov, e_ovf);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_dut(0, 1'b1, 1'b0, 13'd0, 1'b0, 1'b0);
    check_dut(1, 1'b1, 1'b0, 13'd0, 1'b0, 1'b0);
    check_eq({tag, "_d0_we"},   bus0.iccm_cntrl_we, 1'b0);
    check_eq({tag, "_d0_addr"}, bus0.iccm_cntrl_addr, 12'd0);
    check_eq({tag, "_d0_data"}, bus0.iccm_cntrl_data, 32'd0);
    check_eq({tag, "_d1_we"},   bus1.iccm_cntrl_we, 1'b0);
    check_eq({tag, "_d1_addr"}, bus1.iccm_cntrl_addr, 12'd0);
    check_eq({tag, "_d1_data"}, bus1.iccm_cntrl_data, 32'd0);
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_q0_left"}, q0.size(), 0);
    check_eq({tag, "_q1_left"}, q1.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tb_en = 1'b0; tb_ss = 1'b1; tb_mosi = 1'b0;
    repeat (2) tick();
    check_reset_outputs("rst");
    clear_model();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    #1;

    // 1: three frames, strobe latency, release sequence, RUN ignores SPI
    do_reset();
    frame(32'h0000_0013, 1'b1);
    check_eq("lat_we_before", bus0.iccm_cntrl_we, 1'b0);
    tick();
    check_eq("lat_we_high", bus0.iccm_cntrl_we, 1'b1);
    tick();
    check_eq("lat_we_low", bus0.iccm_cntrl_we, 1'b0);
    idle(2);
    frame(32'hDEAD_BEEF, 1'b1); idle(4);
    frame(32'h0000_006F, 1'b1); idle(4);
    check_eq("iccm_reset_before_en", bus0.iccm_cntrl_reset, 1'b1);
    tb_en = 1'b1;
    tick();
    check_eq("iccm_reset_after_en", bus0.iccm_cntrl_reset, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("core_rst_held_%0d", i), bus0.enable_rst_ni, 1'b0);
      tick();
    end
    check_eq("core_rst_held_3", bus0.enable_rst_ni, 1'b0);
    tick();
    check_dut(0, 1'b0, 1'b1, 13'd3, 1'b0, 1'b0);
    check_dut(1, 1'b0, 1'b1, 13'd3, 1'b0, 1'b0);
    frame(32'h5555_5555, 1'b0); idle(3);
    tb_en = 1'b0; idle(3);
    check_dut(0, 1'b0, 1'b1, 13'd3, 1'b0, 1'b0);
    check_empty("t1");

    // 2: eight frames with one idle cycle; small DUT overflows after four
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      frame(32'(i), 1'b1);
      idle(1);
    end
    idle(3);
    check_dut(0, 1'b1, 1'b0, 13'd8, 1'b0, 1'b0);
    check_dut(1, 1'b1, 1'b0, 13'd4, 1'b0, 1'b1);
    check_empty("t2");

    // 3: 17-bit partial frame then a full frame
    do_reset();
    send_bits({32'h89AB_CDEF, 32'h0}, 17);
    idle(1);
    frame(32'hCAFE_F00D, 1'b1); idle(3);
    check_dut(0, 1'b1, 1'b0, 13'd1, 1'b1, 1'b0);
    check_empty("t3");

    // 4: 40 bits in one low period -> one word, extra bits ignored
    do_reset();
    push_word(32'hA5A5_A5A5);
    send_bits({32'hA5A5_A5A5, 8'hFF, 24'h0}, 40);
    idle(4);
    check_dut(0, 1'b1, 1'b0, 13'd1, 1'b0, 1'b0);
    check_empty("t4");

    // 5: asynchronous reset mid-frame, then a fresh frame lands at addr 0
    do_reset();
    frame(32'h1111_2222, 1'b1); idle(2);
    send_bits({32'hFFFF_FFFF, 32'h0}, 20);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    clear_model();
    @(posedge clk); #1;
    tb_ss = 1'b1;
    tick();
    rst_n = 1'b1;
    idle(1);
    frame(32'h1234_5678, 1'b1); idle(3);
    check_dut(0, 1'b1, 1'b0, 13'd1, 1'b0, 1'b0);
    check_empty("t5");

    // 6: strobe pending in the cycle en_i is sampled is still written
    do_reset();
    frame(32'h0BAD_C0DE, 1'b1);
    tb_en = 1'b1;
    tick();
    check_eq("pend_iccm_reset", bus0.iccm_cntrl_reset, 1'b0);
    idle(6);
    check_dut(0, 1'b0, 1'b1, 13'd1, 1'b0, 1'b0);
    check_empty("t6");

    // 7: partial frame cut by en_i is dropped without a frame error
    do_reset();
    send_bits({32'hF0F0_F0F0, 32'h0}, 10);
    tb_en = 1'b1;
    tick();
    idle(6);
    check_dut(0, 1'b0, 1'b1, 13'd0, 1'b0, 1'b0);
    check_empty("t7");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
